// File: rtl/rfft_stream_io.sv
// -----------------------------------------------------------------------------
// rfft_stream_io
//
// Streaming front/back end for a word-oriented real-FFT core. Incoming samples
// are packed four at a time into core words and written to the core during
// its I/O phase. Once the core raises done, the words are read back one at a
// time and replayed as a sample stream.
//
// Frame size: 2^ADDR_W words of 4 samples (256 samples at defaults).
//
// Optional feature (compile-time macro):
//   RFFT_STREAM_IO_BITREV_EN  - read addresses are the ADDR_W-bit bit-reversal
//                               of the read index, so a core that leaves its
//                               result in bit-reversed word order streams out
//                               in natural order. Write addressing is the same
//                               with or without the macro.
//
// Ports
//   Clk              rising-edge clock for all logic
//   Reset            synchronous, active-high reset
//   s_data/s_valid/s_ready        input sample stream
//   m_data/m_valid/m_ready/m_last output sample stream, m_last on final sample
//   Addr             core word address (write address or read address)
//   Din0..Din3       core write lanes, lane 0 = earliest sample of the word
//   Input            core I/O-phase enable
//   Write            core write strobe, one cycle per word
//   done             core completion flag (rising edge honoured in WAIT only)
//   Dout0..Dout3     core read lanes, valid one cycle after the read address
//   busy             high whenever the block is not IDLE
// -----------------------------------------------------------------------------
module rfft_stream_io #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  // input sample stream
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  // output sample stream
  output logic [WIDTH-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  // core interface
  output logic [ADDR_W-1:0] Addr,
  output logic [WIDTH-1:0]  Din0,
  output logic [WIDTH-1:0]  Din1,
  output logic [WIDTH-1:0]  Din2,
  output logic [WIDTH-1:0]  Din3,
  output logic              Input,
  output logic              Write,
  input  logic              done,
  input  logic [WIDTH-1:0]  Dout0,
  input  logic [WIDTH-1:0]  Dout1,
  input  logic [WIDTH-1:0]  Dout2,
  input  logic [WIDTH-1:0]  Dout3,
  output logic              busy
);

  // Sample counter covers a whole frame: word index in the upper bits,
  // lane index in the lowest two bits.
  localparam int CNT_W = ADDR_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    READ,
    CAP,
    SEND
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  samp_cnt;   // samples accepted in the current frame
  logic [WIDTH-1:0]  lane [3];   // lanes 0..2; lane 3 comes straight from s_data
  logic [WIDTH-1:0]  din_q [4];  // word presented to the core
  logic              write_q;    // write strobe, one cycle after a word completes
  logic [ADDR_W-1:0] waddr_q;    // word address of the pending/last write
  logic [ADDR_W-1:0] rd_idx;     // read-back word index
  logic [ADDR_W-1:0] rd_addr;    // core address for rd_idx
  logic [1:0]        k;          // output lane within the captured word
  logic [WIDTH-1:0]  obuf [4];   // captured read word
  logic              done_q;

  logic s_fire;
  logic m_fire;
  logic done_rise;
  logic word_full;
  logic frame_full;
  logic last_lane;
  logic last_word;

  // ---------------------------------------------------------------------------
  // Handshake and terminal-count decodes
  // ---------------------------------------------------------------------------
  assign s_fire     = s_valid && s_ready;
  assign m_fire     = m_valid && m_ready;
  assign done_rise  = done && !done_q;
  assign word_full  = s_fire && (samp_cnt[1:0] == 2'd3);
  assign frame_full = s_fire && (samp_cnt == '1);
  assign last_lane  = (k == 2'd3);
  assign last_word  = (rd_idx == '1);

  // ---------------------------------------------------------------------------
  // Read address mapping
  // ---------------------------------------------------------------------------
`ifdef RFFT_STREAM_IO_BITREV_EN
  always_comb begin
    rd_addr = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      rd_addr[b] = rd_idx[ADDR_W-1-b];
    end
  end
`else
  assign rd_addr = rd_idx;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default at the
  // top; a path that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (s_fire) state_nxt = LOAD;
      // The last word's write strobe fires during the first WAIT cycle, so
      // s_ready is already low there and a 257th sample can never slip in.
      LOAD: if (frame_full) state_nxt = WAIT;
      WAIT: if (done_rise) state_nxt = READ;
      READ: state_nxt = CAP;
      CAP:  state_nxt = SEND;
      SEND: begin
        if (m_fire && last_lane) begin
          state_nxt = last_word ? IDLE : READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Combinational outputs are forced to their idle values while Reset is high
  // so the reset cycle itself presents a quiet interface, whatever state the
  // register still holds.
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    Input   = 1'b0;
    Write   = 1'b0;
    Addr    = '0;
    busy    = 1'b0;
    if (!Reset) begin
      busy    = (state != IDLE);
      s_ready = (state == IDLE) || (state == LOAD);
      Write   = write_q;
      // Input also covers the final write, which lands in the first WAIT cycle.
      Input   = (state == LOAD) || (state == READ) || write_q;
      // The read address is held through CAP/SEND; otherwise show the write
      // address so Addr and Write are always coherent.
      if ((state == READ) || (state == CAP) || (state == SEND)) begin
        Addr = rd_addr;
      end else begin
        Addr = waddr_q;
      end
      if (state == SEND) begin
        m_valid = 1'b1;
        m_data  = obuf[k];
        m_last  = last_lane && last_word;
      end
    end
  end

  assign Din0 = din_q[0];
  assign Din1 = din_q[1];
  assign Din2 = din_q[2];
  assign Din3 = din_q[3];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      samp_cnt <= '0;
      write_q  <= 1'b0;
      waddr_q  <= '0;
      rd_idx   <= '0;
      k        <= '0;
      done_q   <= 1'b0;
      // NOTE: these lane arrays are a handful of flops, not a RAM, so they are
      // cleared on reset like any other register; a real memory would not be.
      for (int i = 0; i < 3; i++) begin
        lane[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        din_q[i] <= '0;
        obuf[i]  <= '0;
      end
    end else begin
      state   <= state_nxt;
      done_q  <= done;
      write_q <= word_full;

      // Input packing: lanes 0..2 are parked; the 4th sample goes straight
      // into the write word so the next sample can be taken without a stall.
      if (s_fire) begin
        case (samp_cnt[1:0])
          2'd0:    lane[0] <= s_data;
          2'd1:    lane[1] <= s_data;
          2'd2:    lane[2] <= s_data;
          default: ;
        endcase
        samp_cnt <= frame_full ? '0 : samp_cnt + CNT_W'(1);
      end

      if (word_full) begin
        din_q[0] <= lane[0];
        din_q[1] <= lane[1];
        din_q[2] <= lane[2];
        din_q[3] <= s_data;
        waddr_q  <= samp_cnt[CNT_W-1:2];
      end

      // Core read data is valid the cycle after the address (CAP).
      if (state == CAP) begin
        obuf[0] <= Dout0;
        obuf[1] <= Dout1;
        obuf[2] <= Dout2;
        obuf[3] <= Dout3;
      end

      if (m_fire) begin
        k <= last_lane ? '0 : k + 2'd1;
        if (last_lane) begin
          rd_idx <= last_word ? '0 : rd_idx + ADDR_W'(1);
          if (last_word) begin
            waddr_q <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rfft_stream_io.sv
// -----------------------------------------------------------------------------
// tb_rfft_stream_io
//
// Bench for rfft_stream_io at default parameters. A simple memory stands in
// for the FFT core (it stores written words and returns them unchanged), so
// the output stream must equal the input frame in word order given by the
// read-address mapping. One negedge process tracks writes, reads and output
// transfers against that model; the directed sequence adds literal checks.
// -----------------------------------------------------------------------------
module tb_rfft_stream_io;

  localparam int W  = 16;
  localparam int AW = 6;
  localparam int NW = 1 << AW;
  localparam int NS = 4 * NW;

`ifdef RFFT_STREAM_IO_BITREV_EN
  localparam logic [AW-1:0] EXP_RD1  = 6'd32;
  localparam logic [W-1:0]  EXP_OUT4 = 16'hA080;
`else
  localparam logic [AW-1:0] EXP_RD1  = 6'd1;
  localparam logic [W-1:0]  EXP_OUT4 = 16'hA004;
`endif

  logic          Clk     = 1'b0;
  logic          Reset   = 1'b1;
  logic [W-1:0]  s_data  = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic [AW-1:0] Addr;
  logic [W-1:0]  Din0, Din1, Din2, Din3;
  logic          Input, Write;
  logic          done    = 1'b0;
  logic [W-1:0]  Dout0   = '0;
  logic [W-1:0]  Dout1   = '0;
  logic [W-1:0]  Dout2   = '0;
  logic [W-1:0]  Dout3   = '0;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [W-1:0]  cur [NS];       // samples of the frame being streamed
  logic [W-1:0]  mem [NW][4];    // stand-in core memory
  int            wr_n   = 0;
  int            rd_n   = 0;
  int            out_n  = 0;
  int            last_n = 0;
  logic [W-1:0]  w0 [4];
  logic [W-1:0]  w63 [4];
  logic [AW-1:0] rd_addr1 = '0;
  logic [W-1:0]  seen_out [NS];
  bit            prev_busy = 1'b0;
  bit            prev_hold = 1'b0;
  logic [W-1:0]  prev_data = '0;

  rfft_stream_io #(.WIDTH(W), .ADDR_W(AW)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .Addr    (Addr),
    .Din0    (Din0),
    .Din1    (Din1),
    .Din2    (Din2),
    .Din3    (Din3),
    .Input   (Input),
    .Write   (Write),
    .done    (done),
    .Dout0   (Dout0),
    .Dout1   (Dout1),
    .Dout2   (Dout2),
    .Dout3   (Dout3),
    .busy    (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core word address used for the i-th read of a frame.
  function automatic logic [AW-1:0] raddr(input int i);
    logic [AW-1:0] v;
    logic [AW-1:0] r;
    v = AW'(i);
`ifdef RFFT_STREAM_IO_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
`else
    r = v;
`endif
    return r;
  endfunction

  // Expected n-th output sample: the echoing core returns the frame's word
  // raddr(n/4), lane n%4.
  function automatic logic [W-1:0] exp_out(input int n);
    return cur[4 * int'(raddr(n / 4)) + (n % 4)];
  endfunction

  // ---------------------------------------------------------------------------
  // Core model and per-cycle compare
  // ---------------------------------------------------------------------------
  always @(negedge Clk) begin
    logic [W-1:0] d [4];
    if (Reset) begin
      wr_n = 0; rd_n = 0; out_n = 0; last_n = 0;
      prev_busy = 1'b0; prev_hold = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        wr_n = 0; rd_n = 0; out_n = 0; last_n = 0;
      end
      prev_busy = busy;

      if (Write) begin
        d = '{Din0, Din1, Din2, Din3};
        check("write_input", Input, 1);
        if (wr_n >= NW) begin
          check("write_count", wr_n, NW - 1);
        end else begin
          check("write_addr", Addr, wr_n);
          for (int l = 0; l < 4; l++) check("write_din", d[l], cur[4 * wr_n + l]);
          for (int l = 0; l < 4; l++) mem[Addr][l] = d[l];
          if (wr_n == 0) w0 = d;
          if (wr_n == NW - 1) w63 = d;
        end
        wr_n++;
      end else if (Input && !s_ready) begin
        check("read_addr", Addr, raddr(rd_n));
        if (rd_n == 1) rd_addr1 = Addr;
        Dout0 = mem[Addr][0];
        Dout1 = mem[Addr][1];
        Dout2 = mem[Addr][2];
        Dout3 = mem[Addr][3];
        rd_n++;
      end

      if (prev_hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end

      if (m_valid) begin
        if (out_n >= NS) begin
          check("output_count", out_n, NS - 1);
        end else begin
          check("m_data", m_data, exp_out(out_n));
          check("m_last", m_last, (out_n == NS - 1));
          if (m_ready) begin
            seen_out[out_n] = m_data;
            if (m_last) last_n++;
            out_n++;
          end
        end
      end else begin
        check("m_last_idle", m_last, 0);
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"},  m_last,  0);
    check({tag, "_m_data"},  m_data,  0);
    check({tag, "_addr"},    Addr,    0);
    check({tag, "_din0"},    Din0,    0);
    check({tag, "_din1"},    Din1,    0);
    check({tag, "_din2"},    Din2,    0);
    check({tag, "_din3"},    Din3,    0);
    check({tag, "_input"},   Input,   0);
    check({tag, "_write"},   Write,   0);
    check({tag, "_busy"},    busy,    0);
  endtask

  // Offer n samples of cur[]; done is raised while sample index done_at is
  // on offer (-1 for never).
  task automatic drive_samples(input int n, input bit gappy, input int done_at);
    int i = 0;
    int g = 0;
    bit fire;
    @(posedge Clk); #1;
    while (i < n && g < 4 * n + 50) begin
      s_valid = gappy ? (g % 2 == 0) : 1'b1;
      s_data  = cur[i];
      done    = (i == done_at);
      @(negedge Clk);
      fire = s_valid && s_ready;
      @(posedge Clk); #1;
      if (fire) i++;
      g++;
    end
    s_valid = 1'b0;
    done    = 1'b0;
    if (i < n) check("load_timeout", i, n);
  endtask

  task automatic post_load(input string tag, input logic [W-1:0] f0, input logic [W-1:0] f3,
                           input logic [W-1:0] l0, input logic [W-1:0] l3);
    repeat (3) @(negedge Clk);
    check({tag, "_writes"},   wr_n,    NW);
    check({tag, "_reads"},    rd_n,    0);
    check({tag, "_input"},    Input,   0);
    check({tag, "_s_ready"},  s_ready, 0);
    check({tag, "_write"},    Write,   0);
    check({tag, "_busy"},     busy,    1);
    check({tag, "_m_valid"},  m_valid, 0);
    check({tag, "_w0_din0"},  w0[0],   f0);
    check({tag, "_w0_din3"},  w0[3],   f3);
    check({tag, "_w63_din0"}, w63[0],  l0);
    check({tag, "_w63_din3"}, w63[3],  l3);
  endtask

  task automatic start_read(input string tag);
    int n = 0;
    @(posedge Clk); #1 done = 1'b1;
    @(posedge Clk); #1 done = 1'b0;
    @(negedge Clk);
    while (!Input && n < 4) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_read0_input"}, Input, 1);
    check({tag, "_read0_addr"},  Addr,  0);
  endtask

  // Accept all outputs. hold: stall m_ready for 5 SEND cycles after output 10;
  // bp: periodic backpressure.
  task automatic drain(input string tag, input bit hold, input bit bp);
    int guard = 0;
    bit held = 1'b0;
    m_ready = 1'b1;
    while (out_n < NS && guard < 4000) begin
      @(posedge Clk); #1;
      guard++;
      if (hold && !held && out_n >= 10) begin
        int seen = 0;
        int g = 0;
        logic [W-1:0] v = '0;
        held = 1'b1;
        m_ready = 1'b0;
        while (seen < 5 && g < 20) begin
          @(negedge Clk);
          g++;
          if (m_valid) begin
            if (seen == 0) v = m_data;
            else check({tag, "_stall_data"}, m_data, v);
            seen++;
          end
        end
        check({tag, "_stall_cycles"}, seen, 5);
        @(posedge Clk); #1 m_ready = 1'b1;
      end else begin
        m_ready = bp ? (guard % 3 != 0) : 1'b1;
      end
    end
    m_ready = 1'b1;
    if (out_n < NS) check({tag, "_drain_timeout"}, out_n, NS);
    repeat (2) @(negedge Clk);
    check({tag, "_outputs"}, out_n,   NS);
    check({tag, "_lasts"},   last_n,  1);
    check({tag, "_busy"},    busy,    0);
    check({tag, "_m_valid"}, m_valid, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < NS; i++) cur[i] = W'(16'hA000 + i);

    // Reset cycle and first cycle after reset
    @(negedge Clk);
    check("rst_cycle_s_ready", s_ready, 0);
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    check_reset_values("por");

    // Frame A: gap-free load, a done pulse during LOAD that must be ignored,
    // then read-out with a 5-cycle stall.
    drive_samples(NS, 1'b0, 100);
    post_load("A", 16'hA000, 16'hA003, 16'hA0FC, 16'hA0FF);
    start_read("A");
    drain("A", 1'b1, 1'b0);
    check("A_rd_addr1", rd_addr1,     EXP_RD1);
    check("A_out0",     seen_out[0],  16'hA000);
    check("A_out4",     seen_out[4],  EXP_OUT4);
    check("A_out255",   seen_out[255], 16'hA0FF);

    // Frame B: same samples with s_valid every other cycle; periodic backpressure.
    drive_samples(NS, 1'b1, -1);
    post_load("B", 16'hA000, 16'hA003, 16'hA0FC, 16'hA0FF);
    start_read("B");
    drain("B", 1'b0, 1'b1);
    check("B_out4", seen_out[4], EXP_OUT4);

    // Frame C: reset after 37 samples, then a fresh full frame.
    for (int i = 0; i < NS; i++) cur[i] = W'(16'h5000 + 3 * i);
    drive_samples(37, 1'b0, -1);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_write",   Write,   0);
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    check_reset_values("mid");
    repeat (3) @(negedge Clk);
    check("mid_no_write", wr_n, 0);
    check("mid_idle",     busy, 0);
    drive_samples(NS, 1'b0, -1);
    post_load("C", 16'h5000, 16'h5009, 16'h52F4, 16'h52FD);
    start_read("C");
    drain("C", 1'b0, 1'b0);
    check("C_out0",   seen_out[0],   16'h5000);
    check("C_out255", seen_out[255], 16'h52FD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rfft_stream_io.md
RFFT_STREAM_IO -- requirements
Module: rfft_stream_io

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6: core word address width (2^ADDR_W words of 4 samples each, so 256 samples per frame).
REQ-003 SHALL have port Clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports s_data (input, WIDTH), s_valid (input, 1) and s_ready (output, 1): input sample stream.
REQ-006 SHALL have ports m_data (output, WIDTH), m_valid (output, 1), m_ready (input, 1) and m_last (output, 1): output sample stream.
REQ-007 SHALL have port Addr, output, ADDR_W: core word address.
REQ-008 SHALL have ports Din0..Din3, output, WIDTH each: core write lanes.
REQ-009 SHALL have ports Input (output, 1) and Write (output, 1): core I/O-phase enable and write strobe.
REQ-010 SHALL have ports done (input, 1) and Dout0..Dout3 (input, WIDTH each): core completion flag and read lanes.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, LOAD, WAIT, READ, CAP, SEND.
REQ-013 IDLE: s_ready=1; the first s_valid&&s_ready transfer SHALL move to LOAD.
REQ-014 LOAD: s_ready=1 and Input=1; accepted samples SHALL fill lanes 0..3 in order, indexed by sample count bits [1:0].
REQ-015 On the accepted 4th sample of a word, all four lanes SHALL be latched into Din0..Din3, and Write SHALL pulse for exactly the next cycle with Addr = word count; a new sample SHALL be accepted in that same cycle without a stall.
REQ-016 After the write of word 2^ADDR_W-1, the block SHALL enter WAIT with s_ready=0, Input=0 and Write=0.
REQ-017 WAIT: a rising edge of done SHALL move to READ; done SHALL be ignored in every other state.
REQ-018 READ: Input=1, Write=0, and Addr = read index; next state SHALL be CAP.
REQ-019 CAP: Dout0..Dout3 SHALL be captured into a 4-lane output buffer (one-cycle core read latency); next state SHALL be SEND.
REQ-020 SEND: m_valid=1 and m_data = buffer lane k, k=0..3; k SHALL advance only on m_valid&&m_ready.
REQ-021 m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-022 After lane 3 is accepted, the block SHALL return to READ with index+1.
REQ-023 m_last SHALL be 1 only on the final sample of the frame (sample 255 at default parameters).
REQ-024 The handshake on the final sample SHALL return the block to IDLE with all counters cleared.
REQ-025 Sample and word counters SHALL wrap modulo their width only via the terminal transitions above; no other overflow path SHALL exist.

Reset
REQ-026 Reset SHALL force state IDLE, clear all counters and lane registers, and drive s_ready=0 in the reset cycle, s_ready=1 in the first cycle after reset, and m_valid=0, m_last=0, m_data=0, Addr=0, Din0..Din3=0, Input=0, Write=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no further Write pulse; resetting the core is the integrator's responsibility.

Configuration
REQ-028 With macro RFFT_STREAM_IO_BITREV_EN defined, the read Addr in READ SHALL be the ADDR_W-bit bit-reversal of the read index, producing natural-order output from a bit-reversed core.
REQ-029 With RFFT_STREAM_IO_BITREV_EN undefined, the read Addr SHALL equal the read index; write addressing is unaffected in both cases.

Verification
REQ-030 Bench SHALL stream 256 samples with no gaps: expect 64 Write pulses, the first with Addr=0 and Din0..Din3 = samples 0..3, the last with Addr=63 and Din = samples 252..255, then Input=0 and s_ready=0.
REQ-031 Bench SHALL send samples with s_valid toggling every other cycle: Din contents are identical to the gap-free case and Write count is 64.
REQ-032 Bench SHALL pulse done while in LOAD and then after the 64th write: only the second pulse starts READ, Addr=0 with Input=1.
REQ-033 Bench SHALL hold m_ready=0 for 5 cycles during SEND: m_data stays constant and no lane is skipped; 256 outputs total with m_last only on the 256th.
REQ-034 Bench SHALL apply Reset during LOAD after 37 samples: all outputs return to reset values, and a fresh 256-sample frame then loads starting at Addr=0.
REQ-035 With RFFT_STREAM_IO_BITREV_EN defined, the second READ SHALL present Addr=32; without it, Addr=1.
